// File: rtl/uart_transmitter_if.sv
// rtl/uart_transmitter_if.sv - byte handshake between the register/FIFO side and the UART transmitter
interface uart_transmitter_if #(
  parameter int DATA_UART = 8
) ();
  logic [DATA_UART-1:0] tx_data_i;
  logic                 tx_valid_i;
  logic                 tx_ready_o;

  modport master (output tx_data_i, output tx_valid_i, input tx_ready_o);
  modport slave  (input tx_data_i, input tx_valid_i, output tx_ready_o);
endinterface

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART TX: start, LSB-first data, optional parity, one or two stop bits
module uart_transmitter #(
  parameter int DIV_SIZE  = 16,
  parameter int DATA_UART = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                stop_bits_i,
  input  logic                parity_bit_i,
  input  logic                parity_mode_i,
  input  logic [DIV_SIZE-1:0] baud_div_i,
  uart_transmitter_if.slave   tx_if,
  output logic                tx_o,
  output logic                tx_busy_o
);

  localparam int BW = $clog2(DATA_UART + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_UART - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [DIV_SIZE-1:0]    cnt_q, cnt_d;
  logic [DIV_SIZE-1:0]    div_q, div_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_UART-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   par_en_q, par_en_d;
  logic                   stop2_q, stop2_d;
  logic                   stop_first_q, stop_first_d;
  logic                   tx_q, tx_d;
  logic                   ready;
  logic                   bit_end;
  logic [DIV_SIZE-1:0]    div_eff;

  assign ready            = (state_q == IDLE) & en_i & ~rst_i;
  assign tx_if.tx_ready_o = ready;
  assign tx_busy_o        = (state_q != IDLE);
  assign tx_o             = tx_q;

  // A latched divisor of 0 is treated as 1 so every bit lasts at least one cycle.
  assign div_eff = (div_q == '0) ? DIV_SIZE'(1) : div_q;
  assign bit_end = (cnt_q == div_eff - DIV_SIZE'(1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_d        = par_q;
    par_en_d     = par_en_q;
    stop2_d      = stop2_q;
    stop_first_d = stop_first_q;
    tx_d         = 1'b1;

    // tx_d is the line level for the state being entered, so tx_o is registered with no extra lag.
    case (state_q)
      IDLE: begin
        if (tx_if.tx_valid_i && ready) begin
          shift_d      = tx_if.tx_data_i;
          par_d        = (^tx_if.tx_data_i) ^ ~parity_mode_i;
          par_en_d     = parity_bit_i;
          stop2_d      = stop_bits_i;
          div_d        = baud_div_i;
          cnt_d        = '0;
          bit_d        = '0;
          stop_first_d = 1'b0;
          state_d      = START;
          tx_d         = 1'b0;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          cnt_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + DIV_SIZE'(1);
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BW'(1);
          if (bit_q == LAST_BIT) begin
            state_d = par_en_q ? PARITY : STOP;
            tx_d    = par_en_q ? par_q : 1'b1;
          end else begin
            tx_d = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + DIV_SIZE'(1);
        end
      end
      PARITY: begin
        tx_d = par_q;
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + DIV_SIZE'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (stop2_q && !stop_first_q) begin
            stop_first_d = 1'b1;
          end else begin
            stop_first_d = 1'b0;
            state_d      = IDLE;
          end
        end else begin
          cnt_d = cnt_q + DIV_SIZE'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      div_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      par_en_q     <= 1'b0;
      stop2_q      <= 1'b0;
      stop_first_q <= 1'b0;
      tx_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      par_en_q     <= par_en_d;
      stop2_q      <= stop2_d;
      stop_first_q <= stop_first_d;
      tx_q         <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - directed vector bench for uart_transmitter
module tb_uart_transmitter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic        stop_bits_i;
  logic        parity_bit_i;
  logic        parity_mode_i;
  logic [15:0] baud_div_i;
  logic        tx_o;
  logic        tx_busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;

  uart_transmitter_if #(.DATA_UART(8)) tx_if ();

  uart_transmitter #(.DIV_SIZE(16), .DATA_UART(8)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .stop_bits_i   (stop_bits_i),
    .parity_bit_i  (parity_bit_i),
    .parity_mode_i (parity_mode_i),
    .baud_div_i    (baud_div_i),
    .tx_if         (tx_if),
    .tx_o          (tx_o),
    .tx_busy_o     (tx_busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i)
    if (!rst_i && tx_if.tx_valid_i && tx_if.tx_ready_o) acc_cnt++;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic        par_en;
    logic        par_mode;
    logic        stop2;
    logic [11:0] exp_bits;   // line level per bit time, bit 0 first
    int          len;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sends one frame, scrambles every config input after accept, then checks each cycle of the frame.
  task automatic send_frame(input vec_t v, input string name);
    int dv;
    dv = (v.div == 16'd0) ? 1 : int'(v.div);
    @(negedge clk_i);
    tx_if.tx_data_i  = v.data;
    baud_div_i       = v.div;
    parity_bit_i     = v.par_en;
    parity_mode_i    = v.par_mode;
    stop_bits_i      = v.stop2;
    tx_if.tx_valid_i = 1'b1;
    check({name, " ready idle"}, 32'(tx_if.tx_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    tx_if.tx_valid_i = 1'b0;
    tx_if.tx_data_i  = ~v.data;
    baud_div_i       = v.div + 16'd3;
    parity_bit_i     = ~v.par_en;
    parity_mode_i    = ~v.par_mode;
    stop_bits_i      = ~v.stop2;
    for (int b = 0; b < v.len; b++) begin
      for (int c = 0; c < dv; c++) begin
        @(negedge clk_i);
        check($sformatf("%s tx bit%0d cyc%0d", name, b, c), 32'(tx_o), 32'(v.exp_bits[b]));
        check({name, " busy"}, 32'(tx_busy_o), 32'd1);
        check({name, " ready low"}, 32'(tx_if.tx_ready_o), 32'd0);
      end
    end
    @(negedge clk_i);
    check({name, " busy end"}, 32'(tx_busy_o), 32'd0);
    check({name, " ready end"}, 32'(tx_if.tx_ready_o), 32'd1);
    check({name, " tx idle"}, 32'(tx_o), 32'd1);
  endtask

  initial begin
    logic [21:0] b2b_exp;
    logic [9:0]  en_exp;
    int          acc_before;

    vecs[0] = '{8'hA5, 16'd4, 1'b0, 1'b0, 1'b0, 12'b0000_0000_0000 | 12'b11_0100_1010, 10};
    vecs[1] = '{8'h03, 16'd2, 1'b1, 1'b1, 1'b0, 12'b100_0000_0110, 11};
    vecs[2] = '{8'h03, 16'd2, 1'b1, 1'b0, 1'b0, 12'b110_0000_0110, 11};
    vecs[3] = '{8'h00, 16'd3, 1'b0, 1'b0, 1'b1, 12'b110_0000_0000, 11};
    vecs[4] = '{8'h81, 16'd1, 1'b0, 1'b0, 1'b0, 12'b11_0000_0010, 10};
    vecs[5] = '{8'h5A, 16'd0, 1'b1, 1'b0, 1'b1, 12'b1110_1011_0100, 12};
    b2b_exp = 22'b11_1010_1010_0110_1010_1010;
    en_exp  = 10'b11_0000_0010;

    rst_i            = 1'b1;
    en_i             = 1'b1;
    stop_bits_i      = 1'b0;
    parity_bit_i     = 1'b0;
    parity_mode_i    = 1'b0;
    baud_div_i       = 16'd4;
    tx_if.tx_data_i  = 8'h00;
    tx_if.tx_valid_i = 1'b0;

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset tx", 32'(tx_o), 32'd1);
    check("reset busy", 32'(tx_busy_o), 32'd0);
    check("reset ready", 32'(tx_if.tx_ready_o), 32'd0);
    rst_i = 1'b0;
    #1;
    check("ready after reset", 32'(tx_if.tx_ready_o), 32'd1);

    for (int i = 0; i < 6; i++) send_frame(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back with valid held: 0x55 then 0xAA, one idle-high cycle between.
    acc_before = acc_cnt;
    @(negedge clk_i);
    baud_div_i       = 16'd1;
    parity_bit_i     = 1'b0;
    stop_bits_i      = 1'b0;
    tx_if.tx_data_i  = 8'h55;
    tx_if.tx_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    tx_if.tx_data_i = 8'hAA;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk_i);
      check($sformatf("b2b tx cyc%0d", i), 32'(tx_o), 32'(b2b_exp[i]));
      if (i == 11) tx_if.tx_valid_i = 1'b0;
    end
    repeat (3) @(negedge clk_i);
    check("b2b accepts", 32'(acc_cnt - acc_before), 32'd2);

    // Enable dropped mid-frame: frame completes, then nothing new is accepted.
    acc_before = acc_cnt;
    @(negedge clk_i);
    tx_if.tx_data_i  = 8'h81;
    tx_if.tx_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    tx_if.tx_valid_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check($sformatf("en tx cyc%0d", i), 32'(tx_o), 32'(en_exp[i]));
      if (i == 3) en_i = 1'b0;
    end
    tx_if.tx_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("en off ready", 32'(tx_if.tx_ready_o), 32'd0);
      check("en off busy", 32'(tx_busy_o), 32'd0);
      check("en off tx", 32'(tx_o), 32'd1);
    end
    check("en off accepts", 32'(acc_cnt - acc_before), 32'd1);
    tx_if.tx_valid_i = 1'b0;
    en_i             = 1'b1;

    // Reset during Data, then a fresh 0x81 frame.
    @(negedge clk_i);
    tx_if.tx_data_i  = 8'h00;
    baud_div_i       = 16'd4;
    tx_if.tx_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    tx_if.tx_valid_i = 1'b0;
    repeat (8) @(negedge clk_i);
    check("rst mid data tx", 32'(tx_o), 32'd0);
    check("rst mid busy", 32'(tx_busy_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rst mid tx", 32'(tx_o), 32'd1);
    check("rst mid busy clr", 32'(tx_busy_o), 32'd0);
    check("rst mid ready", 32'(tx_if.tx_ready_o), 32'd0);
    rst_i = 1'b0;
    send_frame('{8'h81, 16'd2, 1'b0, 1'b0, 1'b0, 12'b11_0000_0010, 10}, "post rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
